// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - beat-aligned LED fade sequencer with shadowed PWM output
module pwm_fade_sequencer #(
    parameter int PWM_WIDTH  = 8,
    parameter int STEP       = 4,
    parameter int HOLD_BEATS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick_stb,
    input  logic                 i_beat_stb,
    input  logic                 i_enable,
    output logic                 o_pwm,
    output logic [PWM_WIDTH-1:0] o_duty,
    output logic [1:0]           o_state,
    output logic                 o_cycle_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RISE = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_FALL = 2'd3;

    localparam logic [PWM_WIDTH-1:0] MAX    = '1;
    localparam logic [PWM_WIDTH:0]   STEP_X = (PWM_WIDTH+1)'(STEP);
    localparam int                   HW     = $clog2(HOLD_BEATS + 1);
    localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_BEATS - 1);

    logic [1:0]           state_q, state_d;
    logic [PWM_WIDTH-1:0] duty_q, duty_d;
    logic [PWM_WIDTH-1:0] active_q, active_d;
    logic [PWM_WIDTH-1:0] cnt_q;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 pwm_q, done_q, done_d;

    logic [PWM_WIDTH:0]   sum_x, diff_x;
    logic [PWM_WIDTH-1:0] rise_duty, fall_duty;

    // Arithmetic carries one extra bit so saturation is detected, never wrapped.
    always_comb begin
        sum_x     = {1'b0, duty_q} + STEP_X;
        diff_x    = {1'b0, duty_q} - STEP_X;
        rise_duty = (sum_x > {1'b0, MAX}) ? MAX : sum_x[PWM_WIDTH-1:0];
        fall_duty = ({1'b0, duty_q} > STEP_X) ? diff_x[PWM_WIDTH-1:0] : '0;
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                duty_d = '0;
                if (i_beat_stb && i_enable) state_d = S_RISE;
            end
            S_RISE: begin
                if (!i_enable) begin
                    state_d = S_FALL;
                end else if (i_tick_stb) begin
                    duty_d = rise_duty;
                    if (rise_duty == MAX) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end
                end
            end
            S_HOLD: begin
                duty_d = MAX;
                if (!i_enable) begin
                    state_d = S_FALL;
                end else if (i_beat_stb) begin
                    if (hold_q == HOLD_LAST) state_d = S_FALL;
                    else                     hold_d  = hold_q + 1'b1;
                end
            end
            default: begin
                if (i_tick_stb) begin
                    duty_d = fall_duty;
                    if (fall_duty == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Shadow captures the pre-edge sequencer duty, so a coincident tick lands next period.
    always_comb begin
        active_d = active_q;
        if (cnt_q == MAX) active_d = duty_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            duty_q   <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            pwm_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            active_q <= active_d;
            cnt_q    <= cnt_q + 1'b1;
            hold_q   <= hold_d;
            pwm_q    <= (cnt_q < active_q);
            done_q   <= done_d;
        end
    end

    assign o_pwm        = pwm_q;
    assign o_duty       = duty_q;
    assign o_state      = state_q;
    assign o_cycle_done = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb/tb_pwm_fade_sequencer.sv - scoreboard bench for pwm_fade_sequencer (STEP=4 and STEP=15 instances)
module tb_pwm_fade_sequencer;

    localparam int MAXV = 15;
    localparam int HB   = 2;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_tick_stb = 1'b0;
    logic       i_beat_stb = 1'b0;
    logic       i_enable = 1'b0;
    logic       pwm0, pwm1, done0, done1;
    logic [3:0] duty0, duty1;
    logic [1:0] st0, st1;

    always #5 clk = ~clk;

    pwm_fade_sequencer #(.PWM_WIDTH(4), .STEP(4), .HOLD_BEATS(2)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_tick_stb(i_tick_stb), .i_beat_stb(i_beat_stb),
        .i_enable(i_enable), .o_pwm(pwm0), .o_duty(duty0), .o_state(st0), .o_cycle_done(done0)
    );

    pwm_fade_sequencer #(.PWM_WIDTH(4), .STEP(15), .HOLD_BEATS(2)) dut_sat (
        .i_clk(clk), .i_rst(i_rst), .i_tick_stb(i_tick_stb), .i_beat_stb(i_beat_stb),
        .i_enable(i_enable), .o_pwm(pwm1), .o_duty(duty1), .o_state(st1), .o_cycle_done(done1)
    );

    typedef struct {
        int st;
        int du;
        int dn;
        int pw;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, duty level, beats counted, and a cycle timeline for the PWM.
    int m_phase[2], m_duty[2], m_beats[2], m_done[2];
    int m_t[2], m_active[2], m_pwm[2];

    task automatic check(input string name, input int k, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_duty[k] = 0; m_beats[k] = 0; m_done[k] = 0;
            m_t[k] = 0; m_active[k] = 0; m_pwm[k] = 0;
        end
    endtask

    task automatic model_step(input bit tick, input bit beat, input bit en);
        for (int k = 0; k < 2; k++) begin
            int stp;
            int pos;
            stp = (k == 0) ? 4 : 15;
            pos = m_t[k] % (MAXV + 1);
            m_pwm[k] = (pos < m_active[k]) ? 1 : 0;
            if (pos == MAXV) m_active[k] = m_duty[k];
            m_t[k]++;
            m_done[k] = 0;
            if (m_phase[k] == 0) begin
                if (beat && en) m_phase[k] = 1;
            end else if (m_phase[k] == 1) begin
                if (!en) m_phase[k] = 3;
                else if (tick) begin
                    m_duty[k] = (m_duty[k] + stp > MAXV) ? MAXV : m_duty[k] + stp;
                    if (m_duty[k] == MAXV) begin m_phase[k] = 2; m_beats[k] = 0; end
                end
            end else if (m_phase[k] == 2) begin
                if (!en) m_phase[k] = 3;
                else if (beat) begin
                    m_beats[k]++;
                    if (m_beats[k] == HB) m_phase[k] = 3;
                end
            end else begin
                if (tick) begin
                    m_duty[k] = (m_duty[k] - stp < 0) ? 0 : m_duty[k] - stp;
                    if (m_duty[k] == 0) begin m_phase[k] = 0; m_done[k] = 1; end
                end
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.st = m_phase[0]; e.du = m_duty[0]; e.dn = m_done[0]; e.pw = m_pwm[0];
        q0.push_back(e);
        e.st = m_phase[1]; e.du = m_duty[1]; e.dn = m_done[1]; e.pw = m_pwm[1];
        q1.push_back(e);
    endtask

    task automatic cycle(input bit tick, input bit beat, input bit en);
        @(negedge clk);
        i_rst = 1'b0;
        i_tick_stb = tick;
        i_beat_stb = beat & tick;
        i_enable = en;
        model_step(tick, beat & tick, en);
        push_expect();
    endtask

    // Asynchronous assert between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        i_tick_stb = 1'b0;
        i_beat_stb = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("async_rst_duty", 0, int'(duty0), 0);
        check("async_rst_state", 0, int'(st0), 0);
        check("async_rst_pwm", 0, int'(pwm0), 0);
        check("async_rst_done", 0, int'(done0), 0);
        check("async_rst_duty", 1, int'(duty1), 0);
        check("async_rst_state", 1, int'(st1), 0);
        model_reset();
        push_expect();
    endtask

    int gen_cnt = 0;
    int gen_ticks = 0;
    task automatic gen_cycle(input bit en);
        bit t, b;
        t = (gen_cnt % 3 == 0);
        b = t && (gen_ticks % 5 == 0);
        if (t) gen_ticks++;
        gen_cnt++;
        cycle(t, b, en);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0 && q1.size() > 0) begin
                exp_t e0, e1;
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                check("state", 0, int'(st0), e0.st);
                check("duty", 0, int'(duty0), e0.du);
                check("cycle_done", 0, int'(done0), e0.dn);
                check("pwm", 0, int'(pwm0), e0.pw);
                check("state", 1, int'(st1), e1.st);
                check("duty", 1, int'(duty1), e1.du);
                check("cycle_done", 1, int'(done1), e1.dn);
                check("pwm", 1, int'(pwm1), e1.pw);
            end
        end
    end

    initial begin : stimulus
        int guard;
        model_reset();
        do_reset();

        // Idle gating: ticks only, then the start beat with no duty change on it.
        for (int i = 0; i < 12; i++) cycle(i % 3 == 0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);

        // Full cycles driven by a 5-ticks-per-beat strobe generator.
        gen_cnt = 0; gen_ticks = 1;
        for (int i = 0; i < 200; i++) gen_cycle(1'b1);

        // Early disable once the STEP=4 instance reaches duty 8 in RISE.
        do_reset();
        cycle(1'b1, 1'b1, 1'b1);
        guard = 0;
        while (!(m_phase[0] == 1 && m_duty[0] == 8) && guard < 50) begin
            cycle(guard % 2 == 0, 1'b0, 1'b1);
            guard++;
        end
        check("early_disable_reached", 0, m_duty[0], 8);
        for (int i = 0; i < 30; i++) cycle(i % 4 == 0, 1'b0, 1'b0);

        // Reset while holding at full duty.
        cycle(1'b1, 1'b1, 1'b1);
        gen_cnt = 1; gen_ticks = 1;
        guard = 0;
        while (m_phase[0] != 2 && guard < 100) begin
            gen_cycle(1'b1);
            guard++;
        end
        check("hold_reached", 0, m_phase[0], 2);
        cycle(1'b0, 1'b0, 1'b1);
        do_reset();

        // Randomized strobes and enable.
        for (int i = 0; i < 2500; i++) begin
            bit t, b, en;
            t  = ($urandom % 4) == 0;
            b  = t && (($urandom % 4) == 0);
            en = ($urandom % 24) != 0;
            cycle(t, b, en);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 0, q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
